// File: rtl/tt_um_inv_rr_arbiter_if.sv
// rtl/tt_um_inv_rr_arbiter_if.sv - Tiny Tapeout pin bundle shared by the arbiter and its driver
interface tt_um_inv_rr_arbiter_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_inv_rr_arbiter.sv
// rtl/tt_um_inv_rr_arbiter.sv - round-robin arbiter sharing one registered 4-bit inverter
module tt_um_inv_rr_arbiter #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    tt_um_inv_rr_arbiter_if.slave       pins
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [1:0] idx_q,   idx_d;
    logic [3:0] data_q,  data_d;
    logic [3:0] hold_q,  hold_d;
    logic [3:0] txn_q,   txn_d;

    logic [3:0] req;
    logic       valid;
    logic       busy;
    logic [3:0] result;
    logic [1:0] gidx;
    logic [3:0] grant;
    logic       unused_ok;

    assign req       = pins.ui_in[3:0];
    assign unused_ok = &{1'b0, pins.uio_in};

    // First set request at or after ptr, wrapping; the reverse scan lets the nearest one win.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] sel;
        sel = p;
        for (int i = 3; i >= 0; i--) begin
            if (r[p + 2'(i)]) sel = p + 2'(i);
        end
        return sel;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            idx_q   <= 2'd0;
            data_q  <= 4'd0;
            hold_q  <= 4'd0;
            txn_q   <= 4'd0;
        end else if (pins.ena) begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            hold_q  <= hold_d;
            txn_q   <= txn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        data_d  = data_q;
        hold_d  = hold_q;
        txn_d   = txn_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    idx_d   = rr_pick(req, ptr_q);
                    data_d  = pins.ui_in[7:4];
                    hold_d  = 4'd0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A released request aborts the grant even on the last hold cycle.
                if (!req[idx_q]) begin
                    state_d = ST_IDLE;
                    ptr_d   = idx_q + 2'd1;
                end else begin
                    hold_d = hold_q + 4'd1;
                    if (hold_q == HOLD_LAST) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!req[idx_q]) begin
                    state_d = ST_IDLE;
                    ptr_d   = idx_q + 2'd1;
                    txn_d   = txn_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        valid  = (state_q == ST_BUSY);
        busy   = (state_q != ST_IDLE);
        result = valid ? ~data_q : 4'd0;
        gidx   = busy ? idx_q : 2'd0;
        grant  = busy ? (4'd1 << idx_q) : 4'd0;
    end

    assign pins.uo_out  = {busy, valid, gidx, result};
    assign pins.uio_out = {txn_q, grant};
    assign pins.uio_oe  = 8'hFF;

endmodule

// File: doc/tt_um_inv_rr_arbiter.md
Name: tt_um_inv_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one registered 4-bit inverter datapath among four requesters. Each requester raises a request line. The granted requester's data nibble is captured, inverted, and presented for a fixed hold window. The grant is held until the requester releases its request (req/grant handshake). The block is a standalone Tiny Tapeout user module and uses the standard TT pin set.

Parameters:
HOLD_CYCLES, 2, number of cycles the inverted result is presented with valid high (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; when 0, all state holds
ui_in  input  8  [3:0] req[3:0] per requester; [7:4] shared data nibble
uo_out  output  8  [3:0] result (~captured data); [5:4] grant index; [6] valid; [7] busy
uio_in  input  8  unused
uio_out  output  8  [3:0] one-hot grant; [7:4] completed-transaction counter
uio_oe  output  8  constant 8'hFF

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ptr=0, grant idx=0, captured data=0, hold counter=0, txn counter=0.
  - uo_out=0; uio_out=0; uio_oe=8'hFF at all times.
- ena=0: no register updates; req and data changes are ignored; outputs hold their current values.
- States: IDLE, BUSY, DONE. All transitions occur on the rising clk edge with ena=1.
- IDLE:
  - If any req is set, select the first set bit scanning ptr, ptr+1, ... mod 4.
  - Register idx, capture ui_in[7:4], clear the hold counter, go to BUSY.
  - If no req is set, remain in IDLE.
- BUSY:
  - Latency: 1 cycle from req sampled to grant, valid and result visible.
  - Outputs: valid=1, busy=1, grant=onehot(idx), result=~captured.
  - Hold counter increments each edge. At the edge where counter==HOLD_CYCLES-1, go to DONE. valid is therefore high for exactly HOLD_CYCLES cycles.
  - Early drop: if req[idx] is sampled 0 in BUSY, go to IDLE. grant clears, ptr=idx+1 mod 4, txn counter unchanged (abort). Early drop takes priority over the hold-done transition.
- DONE:
  - Outputs: valid=0, result=0, busy=1, grant still onehot(idx).
  - Remain in DONE while req[idx]=1.
  - At the edge where req[idx]=0: go to IDLE, ptr=idx+1 mod 4, txn counter +1 (4-bit, 15 wraps to 0).
- Output rules:
  - result (uo_out[3:0]) is 0 whenever valid=0.
  - grant index (uo_out[5:4]) shows idx only while busy; otherwise 0.
  - busy=0 only in IDLE.
- Arbitration:
  - At least one IDLE cycle between consecutive grants.
  - Requests from non-granted requesters are ignored while busy; they are not queued beyond the live req level.
  - Captured data is frozen for the whole grant; ui_in[7:4] changes do not affect the result.
- Fairness: with all four req held continuously, grants rotate 0,1,2,3,0. No requester waits more than 3 other grants.
- Reset mid-operation: immediate return to the reset values above. ptr returns to 0 and the in-flight transaction is not counted.

Test Plan:
- Reset, then req=0001 with data=0xA for one edge and hold req0 -> next cycle grant=0001, uo_out[3:0]=0x5, valid=1 for 2 cycles, then valid=0 with grant held. Drop req0 -> IDLE, uio_out[7:4]=1.
- All req=1111 held, releasing each req one cycle after its valid falls -> grant order 0,1,2,3,0, with one busy=0 cycle between grants and txn counter 1,2,3,4.
- req0 dropped on the first BUSY cycle -> next cycle busy=0, grant=0, txn counter unchanged. A subsequent req1|req0 request grants 1 (ptr advanced).
- ena=0 asserted mid-BUSY for 5 cycles while toggling data and req -> all outputs frozen. The hold window resumes when ena=1, so valid is high for 2 enabled cycles in total.
- 16 complete single-requester transactions -> txn counter wraps to 0; rst_n pulsed low mid-BUSY -> all outputs 0 immediately (asynchronously), uio_oe stays 0xFF.
- HOLD_CYCLES=1 build, req2 with data=0x3 -> result 0xC with valid high for exactly 1 cycle.
